// File: rtl/sprite_lb_pkg.sv
// Shared types and constants for the sprite line buffer.
// Pixel layout is {palette, pen}; pen TRANS_PEN is transparent.
package sprite_lb_pkg;

   localparam int         PIX_W     = 8;
   localparam int         LINE_W    = 256;
   localparam logic [3:0] TRANS_PEN = 4'hF;

   typedef struct packed {
      logic [3:0] pal;
      logic [3:0] pen;
   } pix_t;

   localparam pix_t TRANS_PIX = '{pal: 4'h0, pen: TRANS_PEN};

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } lb_state_t;

endpackage

// File: rtl/sprite_line_buffer_if.sv
// Renderer write port plus display-side outputs of the sprite line buffer.
// Writes are fire-and-forget strobes; there is no backpressure.
interface sprite_line_buffer_if;
   import sprite_lb_pkg::*;

   logic       wr_en;
   logic [7:0] wr_x;
   pix_t       wr_pix;

   logic       ready;
   logic       line_start;
   logic [8:0] line_num;
   pix_t       pix_out;
   logic       pix_opaque;

   modport master (
      output wr_en, wr_x, wr_pix,
      input  ready, line_start, line_num, pix_out, pix_opaque
   );

   modport slave (
      input  wr_en, wr_x, wr_pix,
      output ready, line_start, line_num, pix_out, pix_opaque
   );

endinterface

// File: rtl/sprite_line_buffer_line_ram.sv
// 256-entry line RAM: port A sync read-before-write, port B write-only.
// Read data appears one clk after a_en and holds until the next read; no backpressure.
module line_ram
   import sprite_lb_pkg::*;
(
   input  logic       clk,
   input  logic       a_en,
   input  logic       a_we,
   input  logic [7:0] a_addr,
   input  pix_t       a_wdat,
   output pix_t       a_rdat,
   input  logic       b_we,
   input  logic [7:0] b_addr,
   input  pix_t       b_wdat
);

   logic [PIX_W-1:0] mem [LINE_W];

   always_ff @(posedge clk) begin
      if (a_en) begin
         a_rdat <= mem[a_addr];
      end
      if (a_we) begin
         mem[a_addr] <= a_wdat;
      end
      if (b_we) begin
         mem[b_addr] <= b_wdat;
      end
   end

endmodule

// File: rtl/sprite_line_buffer.sv
// Double-buffered sprite line buffer: renderer fills the draw bank, display bank streams out with hc.
// Readout latency one pixel tick, pre-compensated to align with hc; no backpressure on writes.
module sprite_line_buffer
   import sprite_lb_pkg::*;
#(
   parameter int unsigned ACTIVE_START = 7,
   parameter int unsigned HTOTAL       = 383,
   parameter int unsigned VLINES       = 263
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clk_pix_en,
   input  logic [8:0]           hc,
   input  logic [8:0]           vc,
   input  logic                 vbl,
   sprite_line_buffer_if.slave  lb
);

   localparam logic [8:0] RD_FIRST = 9'(ACTIVE_START - 1);
   localparam logic [8:0] RD_LAST  = 9'(ACTIVE_START + 254);
   localparam logic [8:0] H_LAST   = 9'(HTOTAL);
   localparam logic [9:0] V_TOTAL  = 10'(VLINES);

   lb_state_t  state_q, state_d;
   logic [7:0] sweep_q;
   logic       run, sweep_we;
   logic       bank_q, show_q, line_start_q;
   logic [8:0] line_num_q;
   logic       swap, rd_hit, draw_we;
   logic [7:0] rd_addr, a_addr;
   logic [9:0] ln_sum, ln_next;
   logic       a_en0, a_en1, a_we0, a_we1, b_we0, b_we1;
   pix_t       rd_dat0, rd_dat1, disp_dat;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_CLEAR) begin
            sweep_q <= sweep_q + 8'd1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      run      = 1'b0;
      sweep_we = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            sweep_we = 1'b1;
            if (sweep_q == 8'hFF) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN:   run = 1'b1;
         default:  state_d = ST_CLEAR;
      endcase
   end

   assign swap    = run && clk_pix_en && (hc == H_LAST);
   assign rd_hit  = run && clk_pix_en && (hc >= RD_FIRST) && (hc <= RD_LAST);
   assign rd_addr = 8'(hc - RD_FIRST);
   assign draw_we = run && lb.wr_en && (lb.wr_pix.pen != TRANS_PEN);
   assign a_addr  = sweep_we ? sweep_q : rd_addr;

   // bank_q=0: RAM0 displays, RAM1 draws; a swap-clk write still sees the old bank_q
   assign a_en0 = rd_hit && !bank_q;
   assign a_en1 = rd_hit &&  bank_q;
   assign a_we0 = sweep_we || a_en0;
   assign a_we1 = sweep_we || a_en1;
   assign b_we0 = draw_we &&  bank_q;
   assign b_we1 = draw_we && !bank_q;

   assign ln_sum  = {1'b0, vc} + 10'd2;
   assign ln_next = (ln_sum >= V_TOTAL) ? ln_sum - V_TOTAL : ln_sum;

   always_ff @(posedge clk) begin
      if (reset) begin
         bank_q       <= 1'b0;
         show_q       <= 1'b0;
         line_start_q <= 1'b0;
         line_num_q   <= '0;
      end else begin
         line_start_q <= swap;
         if (run && clk_pix_en) begin
            show_q <= rd_hit && !vbl;
         end
         if (swap) begin
            bank_q     <= ~bank_q;
            line_num_q <= 9'(ln_next);
         end
      end
   end

   line_ram u_ram0 (
      .clk    (clk),
      .a_en   (a_en0),
      .a_we   (a_we0),
      .a_addr (a_addr),
      .a_wdat (TRANS_PIX),
      .a_rdat (rd_dat0),
      .b_we   (b_we0),
      .b_addr (lb.wr_x),
      .b_wdat (lb.wr_pix)
   );

   line_ram u_ram1 (
      .clk    (clk),
      .a_en   (a_en1),
      .a_we   (a_we1),
      .a_addr (a_addr),
      .a_wdat (TRANS_PIX),
      .a_rdat (rd_dat1),
      .b_we   (b_we1),
      .b_addr (lb.wr_x),
      .b_wdat (lb.wr_pix)
   );

   // bank_q cannot change while show_q is set, since the swap tick lies outside the window
   assign disp_dat      = bank_q ? rd_dat1 : rd_dat0;
   assign lb.pix_out    = show_q ? disp_dat : TRANS_PIX;
   assign lb.pix_opaque = show_q && (disp_dat.pen != TRANS_PEN);
   assign lb.ready      = run;
   assign lb.line_start = line_start_q;
   assign lb.line_num   = line_num_q;

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Randomised bench for sprite_line_buffer with a bank/array reference model and directed
// scenarios for display alignment, overwrite, read-clear, swap boundary, vc wrap, vbl and reset.
module tb_sprite_line_buffer;
   import sprite_lb_pkg::*;

   localparam int ACT   = 7;
   localparam int HTOT  = 383;
   localparam int VLN   = 263;
   localparam int LIMIT = 30000;

   logic       clk = 1'b0;
   logic       reset, clk_pix_en, vbl;
   logic [8:0] hc, vc;

   sprite_line_buffer_if lb ();

   sprite_line_buffer #(
      .ACTIVE_START (ACT),
      .HTOTAL       (HTOT),
      .VLINES       (VLN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_pix_en (clk_pix_en),
      .hc         (hc),
      .vc         (vc),
      .vbl        (vbl),
      .lb         (lb)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cycles = 0;
   int         since_rst = 0;
   logic       rdy_prev = 1'b0;
   int         opq_cnt [VLN];

   // reference model: two line arrays, which one is on display, and the expected outputs
   logic [7:0] mbuf [2][256];
   int         m_bank, m_cnt;
   logic [7:0] e_pix;
   logic       e_opq, e_ls;
   logic [8:0] e_ln;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (vc=%0d hc=%0d t=%0t)", tag, act, exp, vc, hc, $time);
      end
   endtask

   task automatic model_edge();
      int a;
      if (reset) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < 256; i++) mbuf[b][i] = 8'h0F;
         m_bank = 0;
         m_cnt  = 0;
         e_pix  = 8'h0F;
         e_opq  = 1'b0;
         e_ls   = 1'b0;
         e_ln   = '0;
      end else if (m_cnt < 256) begin
         m_cnt++;
      end else begin
         e_ls = 1'b0;
         if (clk_pix_en) begin
            if (int'(hc) >= ACT - 1 && int'(hc) <= ACT + 254) begin
               a = int'(hc) - (ACT - 1);
               e_pix = vbl ? 8'h0F : mbuf[m_bank][a];
               mbuf[m_bank][a] = 8'h0F;
            end else begin
               e_pix = 8'h0F;
            end
            e_opq = (e_pix[3:0] != 4'hF);
         end
         if (lb.wr_en && lb.wr_pix.pen != 4'hF) mbuf[1 - m_bank][lb.wr_x] = lb.wr_pix;
         if (clk_pix_en && int'(hc) == HTOT) begin
            m_bank = 1 - m_bank;
            e_ls   = 1'b1;
            e_ln   = 9'((int'(vc) + 2) % VLN);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      if (reset) since_rst = 0;
      else since_rst++;
      @(negedge clk);
      cycles++;
      check("ready",      32'(lb.ready),      32'(m_cnt == 256));
      check("pix_out",    32'(lb.pix_out),    32'(e_pix));
      check("pix_opaque", 32'(lb.pix_opaque), 32'(e_opq));
      check("line_start", 32'(lb.line_start), 32'(e_ls));
      check("line_num",   32'(lb.line_num),   32'(e_ln));
      if (lb.ready && !rdy_prev) check("ready_latency", 32'(since_rst), 32'd256);
      rdy_prev = lb.ready;
   endtask

   task automatic drive_wr(input logic [7:0] x, input logic [7:0] p);
      lb.wr_en  = 1'b1;
      lb.wr_x   = x;
      lb.wr_pix = p;
   endtask

   function automatic logic [8:0] next_vc(input logic [8:0] v);
      if (v == 9'd15)  return 9'd238;
      if (v == 9'd242) return 9'd260;
      return (v == 9'(VLN - 1)) ? 9'd0 : v + 9'd1;
   endfunction

   initial begin
      logic       sb_next;
      logic       mid_done;
      logic [7:0] p;
      int         vbl_sum;

      sb_next  = 1'b0;
      mid_done = 1'b0;
      for (int i = 0; i < VLN; i++) opq_cnt[i] = 0;
      hc = '0; vc = 9'd7; vbl = 1'b0; clk_pix_en = 1'b0; reset = 1'b1;
      lb.wr_en = 1'b0; lb.wr_x = '0; lb.wr_pix = TRANS_PIX;

      @(negedge clk);
      tick();
      tick();
      check("rst_ready",      32'(lb.ready),      32'd0);
      check("rst_pix_out",    32'(lb.pix_out),    32'h0F);
      check("rst_pix_opaque", 32'(lb.pix_opaque), 32'd0);
      check("rst_line_start", 32'(lb.line_start), 32'd0);
      check("rst_line_num",   32'(lb.line_num),   32'd0);
      reset = 1'b0;

      while (!(vc == 9'd5 && hc == 9'd0) && cycles < LIMIT) begin
         clk_pix_en = ($urandom_range(0, 3) != 0);
         lb.wr_en = 1'b0; lb.wr_x = '0; lb.wr_pix = TRANS_PIX;
         if (sb_next) begin
            drive_wr(8'd21, 8'h62);
            sb_next = 1'b0;
         end else if (vc == 9'd10) begin
            if (clk_pix_en) begin
               case (hc)
                  9'd50:   drive_wr(8'd0,   8'h23);
                  9'd51:   drive_wr(8'd255, 8'h45);
                  9'd52:   drive_wr(8'd5,   8'h1F);
                  9'd53:   drive_wr(8'd5,   8'h32);
                  9'd54:   drive_wr(8'd5,   8'h7F);
                  default: ;
               endcase
            end
         end else if (vc == 9'd13 && int'(hc) == HTOT && clk_pix_en) begin
            drive_wr(8'd20, 8'h51);
            sb_next = 1'b1;
         end else if ((vc < 9'd10 || vc > 9'd14) && $urandom_range(0, 2) == 0) begin
            p = 8'($urandom);
            if ($urandom_range(0, 3) == 0) p[3:0] = 4'hF;
            drive_wr(8'($urandom), p);
         end
         if (vc == 9'd2 && hc == 9'd100 && !mid_done) begin
            reset    = 1'b1;
            mid_done = 1'b1;
         end

         tick();
         reset = 1'b0;

         if (lb.line_start) begin
            if (vc == 9'd10)  check("line_num_vc10",  32'(lb.line_num), 32'd12);
            if (vc == 9'd261) check("line_num_vc261", 32'(lb.line_num), 32'd0);
            if (vc == 9'd262) check("line_num_vc262", 32'(lb.line_num), 32'd1);
         end

         // outputs now correspond to the hc the timing generator presents next
         if (clk_pix_en) begin
            if (int'(hc) == HTOT) begin
               hc  = '0;
               vc  = next_vc(vc);
               vbl = (vc >= 9'd240);
            end else begin
               hc = hc + 9'd1;
            end
            if (vc == 9'd11 && hc == 9'd7)   check("l11_x0",       32'(lb.pix_out), 32'h23);
            if (vc == 9'd11 && hc == 9'd12)  check("l11_x5_order", 32'(lb.pix_out), 32'h32);
            if (vc == 9'd11 && hc == 9'd262) check("l11_x255",     32'(lb.pix_out), 32'h45);
            if (vc == 9'd14 && hc == 9'd27)  check("swap_clk_wr",  32'(lb.pix_out), 32'h51);
            if (vc == 9'd14 && hc == 9'd28)  check("swap_p1_early", 32'(lb.pix_out), 32'h0F);
            if (vc == 9'd15 && hc == 9'd28)  check("swap_p1_wr",   32'(lb.pix_out), 32'h62);
            if (vc == 9'd15 && hc == 9'd27)  check("swap_clk_gone", 32'(lb.pix_out), 32'h0F);
            if (lb.pix_opaque) opq_cnt[vc]++;
         end
      end

      check("run_in_budget", 32'(vc == 9'd5 && hc == 9'd0), 32'd1);
      check("opaque_line11", 32'(opq_cnt[11]), 32'd3);
      check("opaque_line12", 32'(opq_cnt[12]), 32'd0);
      check("opaque_line13", 32'(opq_cnt[13]), 32'd0);
      vbl_sum = opq_cnt[240] + opq_cnt[241] + opq_cnt[242] + opq_cnt[260] + opq_cnt[261] + opq_cnt[262];
      check("opaque_vbl", 32'(vbl_sum), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
